// File: rtl/mul16_engine_if.sv
// Start/done handshake plus byte-wide data-memory port shared with dm.
// master = the multiply engine, slave = the host/memory side.
interface mul16_engine_if;
    logic       start;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       mem_wen;
    logic [7:0] mem_wdata;

    modport master (
        input  start,
        input  mem_rdata,
        output done,
        output mem_addr,
        output mem_wen,
        output mem_wdata
    );

    modport slave (
        output start,
        output mem_rdata,
        input  done,
        input  mem_addr,
        input  mem_wen,
        input  mem_wdata
    );
endinterface

// File: rtl/mul16_engine.sv
// Signed 16x16 -> 32 multiply engine: loads operand pairs from dm, shift-add multiplies, stores big-endian.
// Optional MUL_RADIX4_EN: retire two multiplier bits per MUL cycle (8-cycle MUL instead of 16).
module mul16_engine #(
    parameter int NPAIRS   = 16,
    parameter int OP_BASE  = 0,
    parameter int RES_BASE = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    mul16_engine_if.master bus
);

`ifdef MUL_RADIX4_EN
    localparam int MUL_CYCLES = 8;
    localparam int MUL_SHIFT  = 2;
`else
    localparam int MUL_CYCLES = 16;
    localparam int MUL_SHIFT  = 1;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MUL   = 3'd2,
        S_STORE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_start_q;
    logic [3:0]  r_cnt;
    logic [7:0]  r_k;
    logic [15:0] r_a;
    logic [7:0]  r_b_hi;
    logic [31:0] r_mcand;
    logic [15:0] r_mplier;
    logic [31:0] r_acc;
    logic        r_neg;
    logic [7:0]  r_addr_hold;

    logic        w_launch;
    logic        w_active;
    logic        w_abort;
    logic        w_load_end;
    logic        w_mul_end;
    logic        w_store_end;
    logic        w_last_pair;
    logic [15:0] w_b;
    logic [15:0] w_a_mag;
    logic [15:0] w_b_mag;
    logic [31:0] w_step_add;
    logic [31:0] w_result;
    logic [7:0]  w_pair_off;
    logic [7:0]  w_load_addr;
    logic [7:0]  w_store_addr;
    logic [7:0]  w_res_byte [4];

    assign w_launch    = (r_state == S_IDLE) && !bus.start && r_start_q;
    assign w_active    = (r_state == S_LOAD) || (r_state == S_MUL) || (r_state == S_STORE);
    assign w_abort     = w_active && bus.start;
    assign w_load_end  = (r_state == S_LOAD)  && (r_cnt == 4'd3);
    assign w_mul_end   = (r_state == S_MUL)   && (r_cnt == 4'(MUL_CYCLES - 1));
    assign w_store_end = (r_state == S_STORE) && (r_cnt == 4'd3);
    assign w_last_pair = (r_k == 8'(NPAIRS - 1));

    // B's low byte is still on the bus in the last LOAD cycle, so B is assembled combinationally.
    assign w_b     = {r_b_hi, bus.mem_rdata};
    assign w_a_mag = r_a[15] ? 16'(-r_a) : r_a;
    assign w_b_mag = w_b[15] ? 16'(-w_b) : w_b;

`ifdef MUL_RADIX4_EN
    assign w_step_add = (r_mplier[0] ? r_mcand : 32'd0)
                      + (r_mplier[1] ? {r_mcand[30:0], 1'b0} : 32'd0);
`else
    assign w_step_add = r_mplier[0] ? r_mcand : 32'd0;
`endif

    // Negating a zero magnitude yields zero, so the non-zero condition needs no extra gate.
    assign w_result = r_neg ? 32'(-r_acc) : r_acc;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_res_byte
            assign w_res_byte[gi] = w_result[8*gi +: 8];
        end
    endgenerate

    assign w_pair_off   = {r_k[5:0], 2'b00};
    assign w_load_addr  = 8'(OP_BASE)  + w_pair_off + {6'd0, r_cnt[1:0]};
    assign w_store_addr = 8'(RES_BASE) + w_pair_off + {6'd0, r_cnt[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_launch) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                if (w_abort)         w_state_next = S_IDLE;
                else if (w_load_end) w_state_next = S_MUL;
            end
            S_MUL: begin
                if (w_abort)        w_state_next = S_IDLE;
                else if (w_mul_end) w_state_next = S_STORE;
            end
            S_STORE: begin
                if (w_abort)          w_state_next = S_IDLE;
                else if (w_store_end) w_state_next = w_last_pair ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                if (bus.start) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_addr  = r_addr_hold;
        bus.mem_wen   = 1'b0;
        bus.mem_wdata = 8'd0;
        bus.done      = 1'b0;
        case (r_state)
            S_LOAD: begin
                bus.mem_addr = w_load_addr;
            end
            S_STORE: begin
                bus.mem_addr  = w_store_addr;
                bus.mem_wen   = 1'b1;
                bus.mem_wdata = w_res_byte[2'(2'd3 - r_cnt[1:0])];
            end
            S_DONE: begin
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_q   <= 1'b1;
            r_cnt       <= 4'd0;
            r_k         <= 8'd0;
            r_a         <= 16'd0;
            r_b_hi      <= 8'd0;
            r_mcand     <= 32'd0;
            r_mplier    <= 16'd0;
            r_acc       <= 32'd0;
            r_neg       <= 1'b0;
            r_addr_hold <= 8'd0;
        end else begin
            r_start_q <= bus.start;

            if (w_active && (w_state_next == r_state)) r_cnt <= 4'(r_cnt + 4'd1);
            else                                       r_cnt <= 4'd0;

            if (r_state == S_IDLE)                    r_k <= 8'd0;
            else if (w_store_end && !w_last_pair)     r_k <= 8'(r_k + 8'd1);

            if ((r_state == S_LOAD) || (r_state == S_STORE)) r_addr_hold <= bus.mem_addr;

            if (r_state == S_LOAD) begin
                case (r_cnt[1:0])
                    2'd0: r_a[15:8] <= bus.mem_rdata;
                    2'd1: r_a[7:0]  <= bus.mem_rdata;
                    2'd2: r_b_hi    <= bus.mem_rdata;
                    default: begin
                        r_mcand  <= {16'd0, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_neg    <= r_a[15] ^ w_b[15];
                        r_acc    <= 32'd0;
                    end
                endcase
            end

            // Multiplicand shifts up as multiplier bits retire LSB first.
            if (r_state == S_MUL) begin
                r_acc    <= r_acc + w_step_add;
                r_mcand  <= r_mcand << MUL_SHIFT;
                r_mplier <= r_mplier >> MUL_SHIFT;
            end
        end
    end

endmodule

// File: tb/tb_mul16_engine.sv
// Directed/randomized bench for mul16_engine with a byte memory model and a signed-product reference.
module tb_mul16_engine;

`ifdef MUL_RADIX4_EN
    localparam int PER_PAIR = 16;
`else
    localparam int PER_PAIR = 24;
`endif
    localparam int NPAIRS   = 16;
    localparam int RES_BASE = 64;
    localparam int LAT      = PER_PAIR * NPAIRS;

    logic clk;
    logic rst_n;
    mul16_engine_if mif();

    logic [7:0] mem [256];
    shortint    op  [32];
    int         wtotal;
    int         checks;
    int         errors;

    mul16_engine #(.NPAIRS(NPAIRS), .OP_BASE(0), .RES_BASE(RES_BASE)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mif.mem_rdata = mem[mif.mem_addr];

    always @(posedge clk) begin
        if (mif.mem_wen) begin
            mem[mif.mem_addr] <= mif.mem_wdata;
            wtotal <= wtotal + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_prod(input int k);
        int p;
        p = int'(op[2*k+1]) * int'(op[2*k]);
        return p;
    endfunction

    function automatic logic [31:0] mem_word(input int addr);
        return {mem[addr], mem[addr+1], mem[addr+2], mem[addr+3]};
    endfunction

    task automatic write_image();
        for (int i = 0; i < 32; i++) begin
            mem[2*i]   = op[i][15:8];
            mem[2*i+1] = op[i][7:0];
        end
        for (int a = RES_BASE; a < RES_BASE + 4*NPAIRS; a++) mem[a] = 8'hAA;
    endtask

    task automatic random_image();
        for (int i = 0; i < 32; i++) op[i] = shortint'($urandom_range(0, 65535));
        write_image();
    endtask

    task automatic check_products(input string tag, input int first, input int last);
        for (int k = first; k <= last; k++)
            check($sformatf("%s_p%0d", tag, k), mem_word(RES_BASE + 4*k), ref_prod(k));
    endtask

    task automatic run_full(input string tag);
        int n;
        int w0;
        @(negedge clk);
        mif.start = 1'b0;
        w0 = wtotal;
        @(posedge clk);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!mif.done && n < LAT + 50);
        check({tag, "_latency"}, 32'(n), 32'(LAT));
        check({tag, "_writes"}, 32'(wtotal - w0), 32'(4*NPAIRS));
        check_products(tag, 0, NPAIRS-1);
        $display("run %s: latency=%0d writes=%0d", tag, n, wtotal - w0);
        repeat (5) @(posedge clk);
        #1;
        check({tag, "_done_held"}, 32'(mif.done), 32'd1);
        check({tag, "_no_relaunch"}, 32'(wtotal - w0), 32'(4*NPAIRS));
        @(negedge clk);
        mif.start = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_done_fall"}, 32'(mif.done), 32'd0);
    endtask

    initial begin
        int w0;
        int bad;
        checks = 0;
        errors = 0;
        wtotal = 0;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        rst_n     = 1'b0;
        mif.start = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_done", 32'(mif.done), 32'd0);
        check("rst_wen",  32'(mif.mem_wen), 32'd0);
        check("rst_addr", 32'(mif.mem_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("idle_writes", 32'(wtotal), 32'd0);

        // Basic: -5 * 3
        for (int i = 0; i < 32; i++) op[i] = 16'sd0;
        op[0] = -16'sd5;
        op[1] = 16'sd3;
        write_image();
        run_full("basic");
        check("basic_p0_const", mem_word(RES_BASE), 32'hFFFF_FFF1);

        // Corners in pairs 0..4
        random_image();
        op[0] = shortint'(16'h8000); op[1] = shortint'(16'h8000);
        op[2] = shortint'(16'h8000); op[3] = shortint'(16'h7FFF);
        op[4] = shortint'(16'h7FFF); op[5] = shortint'(16'h7FFF);
        op[6] = shortint'(16'hFFFF); op[7] = shortint'(16'h0000);
        op[8] = shortint'(16'hFFFF); op[9] = shortint'(16'hFFFF);
        write_image();
        run_full("corner");
        check("corner_c0", mem_word(RES_BASE+0),  32'h4000_0000);
        check("corner_c1", mem_word(RES_BASE+4),  32'hC000_8000);
        check("corner_c2", mem_word(RES_BASE+8),  32'h3FFF_0001);
        check("corner_c3", mem_word(RES_BASE+12), 32'h0000_0000);
        check("corner_c4", mem_word(RES_BASE+16), 32'h0000_0001);

        for (int r = 0; r < 10; r++) begin
            random_image();
            run_full($sformatf("rand%0d", r));
        end

        // Abort 100 cycles after the launch edge
        random_image();
        @(negedge clk);
        mif.start = 1'b0;
        w0 = wtotal;
        @(posedge clk);
        repeat (100) @(posedge clk);
        #1;
        mif.start = 1'b1;
        @(posedge clk);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (mif.mem_wen || mif.done) bad++;
        end
        check("abort_quiet", 32'(bad), 32'd0);
        check("abort_writes", 32'(wtotal - w0), 32'((101 / PER_PAIR) * 4));
        $display("run abort: writes_before_abort=%0d quiet_violations=%0d", wtotal - w0, bad);
        run_full("post_abort");

        // Reset pulse during STORE of pair 5
        random_image();
        @(negedge clk);
        mif.start = 1'b0;
        @(posedge clk);
        repeat (6*PER_PAIR - 3) @(posedge clk);
        #1;
        check("mid_in_store", 32'(mif.mem_wen), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_done",  32'(mif.done), 32'd0);
        check("mid_rst_wen",   32'(mif.mem_wen), 32'd0);
        check("mid_rst_addr",  32'(mif.mem_addr), 32'd0);
        check("mid_rst_wdata", 32'(mif.mem_wdata), 32'd0);
        mif.start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_products("mid_kept", 0, 4);
        check("mid_p6_untouched", mem_word(RES_BASE + 24), 32'hAAAA_AAAA);
        $display("run reset_mid: pairs 0-4 retained check done");
        run_full("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul16_engine.md
# mul16_engine

Hardware responder for the program-3 start/done protocol: double-precision two's-complement multiply. On a falling edge of `start` it reads 32 signed 16-bit operands from byte-wide data memory and forms 16 signed 32-bit products. It writes them back big-endian and raises `done`. It sits beside `dm` in `top` as a fixed-function alternative to running program 3 on the core, and shares the same memory port.

## Interface
- `NPAIRS`, default 16: number of operand pairs (products).
- `OP_BASE`, default 0: byte address of operand 0.
- `RES_BASE`, default 64: byte address of product 0.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request. High means hold idle; a high-to-low transition launches a run.
- `done` output 1: acknowledge. High from run completion until `start` returns high.
- `mem_addr` output 8: byte address to `dm`.
- `mem_rdata` input 8: combinational read data for `mem_addr`, valid in the same cycle.
- `mem_wen` output 1: write enable; `dm` writes `mem_wdata` at the next rising edge.
- `mem_wdata` output 8: write data.

## Operation
- Operand i = {mem[OP_BASE+2i], mem[OP_BASE+2i+1]}, high byte first.
- Product k = operand[2k+1] × operand[2k], stored at RES_BASE+4k … +4k+3, MSB first.
- `start_q` is a register holding the previous `start`; its reset value is 1. A launch occurs in IDLE when `start`=0 and `start_q`=1.
- FSM:
  - IDLE → LOAD on launch.
  - LOAD: 4 cycles, reading A_hi, A_lo, B_hi, B_lo where A = operand[2k], B = operand[2k+1]. Each byte is captured at the end of its cycle. Then go to MUL.
  - MUL: 16 cycles, then go to STORE.
  - STORE: 4 cycles writing P[31:24], P[23:16], P[15:8], P[7:0].
  - After STORE: if k = NPAIRS−1 go to DONE, else increment k and return to LOAD.
  - DONE: hold `done`=1. Go to IDLE when `start`=1.
- Arithmetic is sign-magnitude:
  - |A| and |B| are 16-bit unsigned; 0x8000 is treated as 32768.
  - Unsigned shift-add produces a 32-bit magnitude, one multiplier bit per cycle, LSB first.
  - The result is negated if sign(A) ≠ sign(B) and the magnitude is non-zero.
  - −32768 × −32768 = 0x40000000 with no overflow.
- Abort: `start`=1 in any state other than IDLE or DONE returns the FSM to IDLE next cycle.
  - `mem_wen` is 0 from that cycle on.
  - Partial results already written remain in memory.
  - `done` stays 0.
- Reset, asserted any time (including mid-run): immediately forces IDLE and drives every output to its reset value.
- Reset values:
  - `done`=0, `mem_wen`=0, `mem_addr`=0, `mem_wdata`=0.
  - k=0, `start_q`=1.
- `mem_addr` holds its last value when no access is in progress.

## Timing
- Per pair: 4 (LOAD) + 16 (MUL) + 4 (STORE) = 24 cycles.
- Launch edge is E, where `start`=0 is sampled in IDLE. The first LOAD cycle is E+1. `done` rises at the edge ending cycle E+24·NPAIRS, i.e. 384 cycles after E for NPAIRS=16.
- The last byte write and `done`=1 take effect on the same edge, so all products are visible in memory when `done` is first seen high.
- `done` falls on the first edge that samples `start`=1.
- A new launch requires `start` to be sampled high, then low. Holding `start` low after DONE never relaunches.
- There is no back-pressure: memory is assumed to accept one access per cycle.

## Configuration
- `MUL_RADIX4_EN` defined: MUL consumes 2 multiplier bits per cycle and takes 8 cycles. Per pair is 16 cycles; `done` arrives 256 cycles after E.
- `MUL_RADIX4_EN` undefined: radix-2 as specified above, 16-cycle MUL. Results are bit-identical in both modes.

## Test plan
- Reset: hold `rst_n`=0 with `start`=1 → `done`=0, `mem_wen`=0, `mem_addr`=0. Release with `start` held high → no memory writes.
- Basic: operand0=−5, operand1=3, all others 0, drop `start` → mem[64..67]=FF FF FF F1, mem[68..127]=0. `done` rises exactly 384 cycles after E (256 with `MUL_RADIX4_EN`).
- Corners, one per pair:
  - 0x8000×0x8000 → 40000000.
  - 0x7FFF×0x8000 → C0008000.
  - 0x7FFF×0x7FFF → 3FFF0001.
  - 0×0xFFFF → 00000000.
  - 0xFFFF×0xFFFF → 00000001.
- Full random: 10 random memory images, each driven with a `start` 1→0 launch → all 16 products match the signed reference model, and every `done` falls one edge after `start` rises.
- Abort: raise `start` 100 cycles after E → `mem_wen` stays 0 from the next cycle and `done` stays 0. A following 1→0 launch produces all 16 correct products.
- Reset mid-run: pulse `rst_n` low during the STORE of pair 5 → outputs return to reset values asynchronously. Pairs 0–4 remain in memory; a later launch completes all 16 correctly.
